// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the prefetching fetch queue.
package fetch_queue_pkg;

  localparam int XLEN = 32;
  localparam int PC_W = 32;

  localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // One buffered fetch result: the PC it was fetched from and the word returned.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return addr & ~(PC_W'(3));
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// In-order first-word-fall-through FIFO of {pc, ir} entries with flush.
// The head entry is presented combinationally so a pushed entry is visible
// the cycle after it is written. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;
  fetch_entry_t  entry_q [DEPTH];

  // Flush wins over both ports; a push into a full FIFO is only taken when the
  // head leaves in the same cycle (the freed slot is the one being written).
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      fetch_entry_t entry_reg;

      // Capture the pushed entry when the write pointer selects this slot.
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == AW'(gi))) begin
          entry_reg <= push_data;
        end
      end

      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_data = entry_q[rd_ptr_reg];
  assign count     = count_reg;
  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);

endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch stage feeding the IF/ID register.
// Issues sequential word fetches under a credit limit of DEPTH (queued plus
// outstanding), buffers the in-order responses and flushes on redirect,
// discarding responses to requests issued before the redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  output logic [PC_W-1:0] out_pc,
  output logic [XLEN-1:0] out_ir
);

  localparam int            CW         = $clog2(DEPTH + 1);
  localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(DEPTH);

  logic [PC_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [PC_W-1:0] pc_tail_reg, pc_tail_next;
  logic [CW-1:0]   inflight_reg, inflight_next;
  logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
  logic            reset_q_reg;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_full_unused;
  fetch_entry_t    head_data;
  fetch_entry_t    push_data;

  logic [CW:0]     credits_used;
  logic            issue;
  logic            rsp_ok;
  logic            rsp_drop;
  logic            push;
  logic            pop;

  // Every queued entry and every outstanding request holds one credit.
  assign credits_used = {1'b0, fifo_count} + {1'b0, inflight_reg};
  assign imem_req     = !reset && !reset_q_reg && !redirect && (credits_used < CREDIT_MAX);
  assign imem_addr    = fetch_pc_reg;
  assign issue        = imem_req && imem_gnt;

  // A response with nothing outstanding is a protocol violation and is ignored.
  // Responses are dropped while stale requests remain, or when they coincide
  // with a redirect.
  assign rsp_ok   = imem_rvalid && (inflight_reg != '0);
  assign rsp_drop = rsp_ok && (redirect || (drop_cnt_reg != '0));
  assign push     = rsp_ok && !rsp_drop && !reset;
  assign pop      = out_valid && !stall && !redirect;

  // Responses are in order, so pc_tail is always the PC of the oldest live request.
  assign push_data = '{pc: pc_tail_reg, ir: imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .srst      (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign fifo_full_unused = fifo_full;

  assign out_valid = !fifo_empty;
  assign out_pc    = out_valid ? head_data.pc : '0;
  assign out_ir    = out_valid ? head_data.ir : NOP_WORD;

  // Next-state for fetch/tail PCs and the outstanding/stale request counters.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    pc_tail_next  = pc_tail_reg;
    inflight_next = inflight_reg;
    drop_cnt_next = drop_cnt_reg;
    if (redirect) begin
      // Everything still outstanding after this cycle belongs to the old stream.
      fetch_pc_next = word_align(redirect_pc);
      pc_tail_next  = word_align(redirect_pc);
      inflight_next = inflight_reg - CW'(rsp_ok);
      drop_cnt_next = inflight_reg - CW'(rsp_ok);
    end else begin
      if (issue) begin
        fetch_pc_next = fetch_pc_reg + PC_W'(4);
      end
      if (push) begin
        pc_tail_next = pc_tail_reg + PC_W'(4);
      end
      if (rsp_drop) begin
        drop_cnt_next = drop_cnt_reg - CW'(1);
      end
      inflight_next = inflight_reg + CW'(issue) - CW'(rsp_ok);
    end
  end

  // State registers; reset_q holds issue off for the first cycle after reset.
  always_ff @(posedge clk) begin
    reset_q_reg <= reset;
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
      pc_tail_reg  <= RESET_PC;
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      pc_tail_reg  <= pc_tail_next;
      inflight_reg <= inflight_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a bench-side memory answers granted
// requests after a programmable latency, live responses push expected
// {pc, ir} pairs and the head of the DUT queue is compared every cycle.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RST_PC   = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_ir;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_ir      (out_ir)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          epoch;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  pend_t       pend[$];
  ent_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          infl = 0;
  int          lat = 1;
  bit          prev_reset = 1'b0;
  bit          gnt_rand = 1'b0;
  int          first_gnt = -1;
  int          first_valid = -1;
  logic [31:0] exp_addr = RST_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = a[15:0];
    hi = a[31:16];
    return {lo ^ 16'hC3A5, hi ^ lo ^ 16'h0F1E};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: present the memory response, check outputs, then update
  // the scoreboard with what the coming rising edge does.
  task automatic cycle();
    pend_t p;
    ent_t  e;
    logic  exp_req;
    if (gnt_rand) imem_gnt = 1'($urandom_range(0, 1));
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    exp_req = !reset && !prev_reset && !redirect && ((exp_q.size() + infl) < DEPTH);
    check_eq("req", imem_req, exp_req);
    if (!reset) begin
      check_eq("valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        check_eq("head_pc", out_pc, exp_q[0].pc);
        check_eq("head_ir", out_ir, exp_q[0].ir);
      end else begin
        check_eq("idle_pc", out_pc, 32'h0);
        check_eq("idle_ir", out_ir, 32'h0);
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && !stall && !redirect && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("%0t pop pc=%08h ir=%08h", $time, e.pc, e.ir);
      end
    end
    if (imem_rvalid) begin
      p = pend.pop_front();
      if (infl > 0 && !reset) begin
        infl--;
        if (p.epoch == epoch && !redirect) begin
          e.pc = p.pc;
          e.ir = mem_word(p.pc);
          exp_q.push_back(e);
        end
      end
    end
    if (imem_req && imem_gnt) begin
      check_eq("addr", imem_addr, exp_addr);
      p.pc    = exp_addr;
      p.data  = mem_word(imem_addr);
      p.epoch = epoch;
      p.due   = cyc + lat;
      pend.push_back(p);
      exp_addr = exp_addr + 32'd4;
      infl++;
      if (first_gnt < 0) first_gnt = cyc;
    end
    if (reset) begin
      exp_q.delete();
      infl        = 0;
      epoch++;
      exp_addr    = RST_PC;
      first_gnt   = -1;
      first_valid = -1;
    end else if (redirect) begin
      exp_q.delete();
      epoch++;
      exp_addr = redirect_pc & 32'hFFFF_FFFC;
    end
    prev_reset = reset;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      cycle();
      n++;
    end
    if (!out_valid) check_eq(tag, out_valid, 32'h1);
  endtask

  initial begin
    int n;
    // Reset release and streaming with single-cycle memory.
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    #1;
    check_eq("rst_valid", out_valid, 32'h0);
    check_eq("rst_pc", out_pc, 32'h0);
    check_eq("rst_ir", out_ir, 32'h0);
    check_eq("rst_req", imem_req, 32'h0);
    repeat (12) cycle();
    check_eq("first_lat", first_valid - first_gnt, 32'd2);

    // Stall: queue fills, issue stops, then drains in order.
    stall = 1'b1;
    repeat (6) cycle();
    check_eq("stall_req", imem_req, 32'h0);
    stall = 1'b0;
    repeat (10) cycle();

    // Redirect with three requests in flight; low address bits ignored.
    lat = 3;
    n = 0;
    while (infl != 3 && n < 20) begin cycle(); n++; end
    redirect = 1'b1;
    redirect_pc = 32'h0000_4013;
    cycle();
    redirect = 1'b0;
    check_eq("redir_addr", imem_addr, 32'h0000_4010);
    wait_valid("redir_wait");
    check_eq("redir_pc", out_pc, 32'h0000_4010);

    // Redirect coincident with a response while stalled.
    lat = 2;
    stall = 1'b1;
    n = 0;
    while (!(pend.size() > 0 && pend[0].due <= cyc) && n < 20) begin cycle(); n++; end
    redirect = 1'b1;
    redirect_pc = 32'h0000_5000;
    cycle();
    redirect = 1'b0;
    check_eq("flush_empty", out_valid, 32'h0);
    cycle();
    stall = 1'b0;
    wait_valid("rv_wait");
    check_eq("rv_pc", out_pc, 32'h0000_5000);

    // Back-to-back redirects.
    lat = 3;
    repeat (5) cycle();
    redirect = 1'b1;
    redirect_pc = 32'h0000_6000;
    cycle();
    redirect_pc = 32'h0000_7000;
    cycle();
    redirect = 1'b0;
    wait_valid("b2b_wait");
    check_eq("b2b_pc", out_pc, 32'h0000_7000);

    // Reset with entries queued and requests outstanding.
    stall = 1'b1;
    n = 0;
    while (!(exp_q.size() >= 2 && infl >= 2) && n < 30) begin cycle(); n++; end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    imem_gnt = 1'b0;
    #1;
    check_eq("rst2_valid", out_valid, 32'h0);
    check_eq("rst2_ir", out_ir, 32'h0);
    check_eq("rst2_req", imem_req, 32'h0);
    n = 0;
    while (pend.size() > 0 && n < 20) begin cycle(); n++; end
    stall = 1'b0;
    imem_gnt = 1'b1;
    #1;
    check_eq("rst2_req_on", imem_req, 32'h1);
    check_eq("rst2_addr", imem_addr, RST_PC);
    repeat (8) cycle();

    // Address wrap at the top of the address space.
    lat = 1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    wait_valid("wrap_wait0");
    check_eq("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    cycle();
    wait_valid("wrap_wait1");
    check_eq("wrap_pc1", out_pc, 32'h0000_0000);
    repeat (4) cycle();

    // Random grants, latencies, stalls and redirects.
    gnt_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      lat = $urandom_range(1, 3);
      stall = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      cycle();
    end
    gnt_rand = 1'b0;
    imem_gnt = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    repeat (20) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
